// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard/stall controller signal bundle
interface pipeline_hazard_ctrl_if;
    logic [2:0]  IF_ID_src1;
    logic [2:0]  IF_ID_src2;
    logic        IF_ID_uses_src2;
    logic [2:0]  ID_EX_dest;
    logic        ID_EX_reg_write;
    logic        ID_EX_mem_read;
    logic        branch_taken;
    logic        mem_busy;
    logic        pc_write;
    logic        IF_ID_write;
    logic        IF_ID_flush;
    logic        ID_EX_write;
    logic        ID_EX_flush;
    logic        EX_MEM_write;
    logic [15:0] stall_count;

    modport master (
        output IF_ID_src1, IF_ID_src2, IF_ID_uses_src2, ID_EX_dest,
        output ID_EX_reg_write, ID_EX_mem_read, branch_taken, mem_busy,
        input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
        input  EX_MEM_write, stall_count
    );

    modport slave (
        input  IF_ID_src1, IF_ID_src2, IF_ID_uses_src2, ID_EX_dest,
        input  ID_EX_reg_write, ID_EX_mem_read, branch_taken, mem_busy,
        output pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
        output EX_MEM_write, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use/branch/memory-busy hazard controller
// Mealy controller driving pipeline register enables and flushes.
module pipeline_hazard_ctrl #(
    parameter int STALL_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN, STALL, FREEZE} state_t;
    typedef enum logic [1:0] {M_NORMAL, M_BUBBLE, M_FLUSH, M_FREEZE} mode_t;

    localparam logic [2:0] CNT_INIT = (STALL_CYCLES > 1) ? 3'(STALL_CYCLES - 2) : 3'd0;

    state_t      state_q, state_d;
    state_t      saved_q, saved_d;
    state_t      ctx;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] stall_count_q, stall_count_d;
    mode_t       mode;
    logic        hazard;

    assign hazard = bus.ID_EX_mem_read & bus.ID_EX_reg_write &
                    ((bus.ID_EX_dest == bus.IF_ID_src1) |
                     (bus.IF_ID_uses_src2 & (bus.ID_EX_dest == bus.IF_ID_src2)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            saved_q       <= RUN;
            cnt_q         <= 3'd0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            saved_q       <= saved_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        cnt_d   = cnt_q;
        mode    = M_NORMAL;
        // Leaving FREEZE behaves exactly like the state that was interrupted.
        ctx     = (state_q == FREEZE) ? saved_q : state_q;
        if (bus.mem_busy) begin
            mode    = M_FREEZE;
            state_d = FREEZE;
            if (state_q != FREEZE) saved_d = state_q;
        end else if (bus.branch_taken) begin
            mode    = M_FLUSH;
            state_d = RUN;
        end else if (ctx == STALL) begin
            mode = M_BUBBLE;
            if (cnt_q == 3'd0) begin
                state_d = RUN;
            end else begin
                cnt_d   = cnt_q - 3'd1;
                state_d = STALL;
            end
        end else if (hazard) begin
            mode = M_BUBBLE;
            if (STALL_CYCLES > 1) begin
                cnt_d   = CNT_INIT;
                state_d = STALL;
            end else begin
                state_d = RUN;
            end
        end else begin
            state_d = RUN;
        end
        if (reset) mode = M_FREEZE;
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (mode == M_BUBBLE && stall_count_q != 16'hFFFF)
            stall_count_d = stall_count_q + 16'd1;
    end

    always_comb begin
        bus.pc_write     = 1'b1;
        bus.IF_ID_write  = 1'b1;
        bus.IF_ID_flush  = 1'b0;
        bus.ID_EX_write  = 1'b1;
        bus.ID_EX_flush  = 1'b0;
        bus.EX_MEM_write = 1'b1;
        case (mode)
            M_BUBBLE: begin
                bus.pc_write    = 1'b0;
                bus.IF_ID_write = 1'b0;
                bus.ID_EX_flush = 1'b1;
            end
            M_FLUSH: begin
                bus.IF_ID_flush = 1'b1;
                bus.ID_EX_flush = 1'b1;
            end
            M_FREEZE: begin
                bus.pc_write     = 1'b0;
                bus.IF_ID_write  = 1'b0;
                bus.ID_EX_write  = 1'b0;
                bus.EX_MEM_write = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.stall_count = stall_count_q;
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the 5-stage 8-bit pipeline with 19-bit instructions. It sequences the PC, IF_ID, ID_EX and EX_MEM pipeline registers through their write-enable and flush controls:
- inserts load-use bubbles, optionally multi-cycle;
- flushes the wrong-path instructions on a taken branch;
- freezes the whole pipe while data memory is busy.

It also keeps a saturating count of load-use bubble cycles for performance debug.

## Interface
Parameters:
- STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal 1..7)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- IF_ID_src1  input  3  first source register of the instruction in ID
- IF_ID_src2  input  3  second source register of the instruction in ID
- IF_ID_uses_src2  input  1  1 = src2 is read by the ID instruction
- ID_EX_dest  input  3  destination register of the instruction in EX
- ID_EX_reg_write  input  1  EX instruction writes the register file
- ID_EX_mem_read  input  1  EX instruction is a load
- branch_taken  input  1  branch in EX resolved taken this cycle
- mem_busy  input  1  data memory not ready; whole pipe must hold
- pc_write  output  1  PC load enable
- IF_ID_write  output  1  IF_ID load enable
- IF_ID_flush  output  1  IF_ID loads a NOP
- ID_EX_write  output  1  ID_EX load enable
- ID_EX_flush  output  1  ID_EX loads zero controls (bubble)
- EX_MEM_write  output  1  EX_MEM load enable
- stall_count  output  16  load-use bubble cycles since reset, saturating

## Operation
**Hazard definition**
- hazard = ID_EX_mem_read & ID_EX_reg_write & (ID_EX_dest==IF_ID_src1 | (IF_ID_uses_src2 & ID_EX_dest==IF_ID_src2)).
- Register 0 is not special.

**State machine**
- States: RUN, STALL, FREEZE.
- 3-bit counter cnt.
- saved_state register (RUN/STALL), used to return from FREEZE.

**Output modes** (Mealy: outputs depend on state plus current inputs)
- normal: pc_write=IF_ID_write=ID_EX_write=EX_MEM_write=1, flushes=0.
- bubble: pc_write=0, IF_ID_write=0, ID_EX_flush=1, ID_EX_write=1, EX_MEM_write=1, IF_ID_flush=0.
- flush: all writes=1, IF_ID_flush=1, ID_EX_flush=1.
- freeze: all writes=0, all flushes=0.

**Priority, every cycle:** reset > mem_busy > branch_taken > hazard / STALL.

**RUN**
- mem_busy: freeze mode; saved_state<=RUN; go to FREEZE.
- else branch_taken: flush mode; stay in RUN.
- else hazard: bubble mode.
  - If STALL_CYCLES>1: cnt<=STALL_CYCLES-2; go to STALL.
  - Otherwise stay in RUN.
- else: normal mode.

**STALL**
- mem_busy: freeze mode; saved_state<=STALL; cnt held; go to FREEZE.
- else branch_taken: flush mode; abort the stall; go to RUN.
- else: bubble mode.
  - If cnt==0, go to RUN.
  - Otherwise cnt<=cnt-1.

**FREEZE**
- Freeze mode while mem_busy=1; cnt and branch_taken are ignored.
- On mem_busy=0, outputs are those of saved_state evaluated this cycle (same rules as above, including branch and hazard). The next state follows from that evaluation.

**stall_count**
- +1 on every cycle in bubble mode; saturates at 16'hFFFF.
- Flush and freeze cycles are not counted.

## Timing
- Zero-cycle latency: outputs respond combinationally to inputs in the same cycle. State, cnt and stall_count update on the next rising edge.
- A load-use hazard costs exactly STALL_CYCLES bubble cycles when it is not interrupted. The detection cycle counts as the first.
- A freeze inserted mid-stall does not shorten or extend the remaining bubble count.
- Taken branch: exactly 1 flush cycle. Wrong-path instructions in IF_ID and ID_EX become NOP/bubble on that edge.
- Branch and hazard in the same cycle: flush only; no bubble; stall_count unchanged.
- Reset:
  - While reset=1: all write enables 0, all flushes 0.
  - On the edge: state<=RUN, cnt<=0, saved_state<=RUN, stall_count<=0.
  - Reset mid-STALL or mid-FREEZE discards the pending stall.
- First cycle after reset with idle inputs: normal mode.

## Test plan
- STALL_CYCLES=1; ID_EX load to r3 (mem_read=1, reg_write=1), IF_ID_src1=3 -> one cycle with pc_write=0, IF_ID_write=0, ID_EX_flush=1; the next cycle (inputs cleared) is normal; stall_count=1.
- STALL_CYCLES=3; same hazard held one cycle then cleared -> 3 consecutive bubble cycles, then normal; stall_count=3. Repeat with IF_ID_uses_src2=0 and only src2 matching -> no bubble.
- STALL_CYCLES=3; hazard, then mem_busy=1 for 2 cycles starting at bubble 2 -> bubble, freeze, freeze, bubble, bubble, normal; stall_count=3.
- branch_taken=1 and hazard in the same cycle -> IF_ID_flush=1, ID_EX_flush=1, pc_write=1; stall_count unchanged. branch_taken during STALL -> flush, then RUN with normal outputs.
- mem_busy=1 with branch_taken=1 for 4 cycles -> all enables 0; on release the same cycle shows flush mode.
- Preload stall_count near 16'hFFFF via a long hazard run -> holds at 16'hFFFF. Reset asserted mid-STALL -> enables 0 during reset; afterwards RUN, stall_count=0.
